fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of MyCPU; owns the PC register and produces its next value.
- Issues word requests to instruction memory and buffers returned instructions in a small queue.
- Hands {pc, inst} to decode via valid/ready.
- Branch/jump/exception redirects flush the queue and any in-flight response.

Parameters:
ADDR_W, 32, PC/address width
DATA_W, 32, instruction width
RESET_PC, 32'hBFC0_0000, PC loaded on reset
Q_DEPTH, 2, instruction queue entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets)
redirect_valid  in  1  load redirect_pc, flush stage
redirect_pc  in  ADDR_W  redirect target
imem_req  out  1  request valid
imem_addr  out  ADDR_W  word address of request
imem_gnt  in  1  request accepted this cycle (req&&gnt = handshake)
imem_rvalid  in  1  response data valid; exactly one per granted request, in order
imem_rdata  in  DATA_W  instruction word
id_valid  out  1  queue head valid
id_ready  in  1  decode consumes head
id_pc  out  ADDR_W  PC of head instruction
id_inst  out  DATA_W  head instruction

Behaviour:
- Reset: pc=RESET_PC, state=IDLE, queue empty, discard=0; imem_req=0, id_valid=0, id_pc=0, id_inst=0.
- States:
  - IDLE: imem_req=0.
  - REQ: imem_req=1, imem_addr=pc.
  - WAIT: granted, awaiting imem_rvalid.
- Max one outstanding request.
- IDLE->REQ when (q_count + outstanding) < Q_DEPTH and !redirect_valid. Space is reserved, so the queue never overflows.
- REQ:
  - imem_addr holds stable until gnt.
  - On gnt: pc<=pc+4 (wraps mod 2^ADDR_W), req_pc<=imem_addr, ->WAIT.
- WAIT: on rvalid:
  - If !discard, push {req_pc, imem_rdata}; clear discard.
  - Then ->REQ if space remains, else ->IDLE.
  - rvalid in the same cycle as gnt is not permitted (memory latency >=1).
- Latency:
  - First imem_req is asserted the cycle after rst rises.
  - A pushed entry is visible on id_* the cycle after rvalid (registered queue).
- Decode handshake:
  - id_valid = queue non-empty.
  - Pop when id_valid && id_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including full and empty with push. A push on empty is not bypassed.
- Redirect (highest priority, one cycle):
  - Queue cleared; pop that cycle is irrelevant.
  - pc<=redirect_pc.
  - In REQ without gnt: request abandoned, imem_req=0 next cycle.
  - In REQ with gnt, or in WAIT: discard<=1; the response is dropped when it arrives. The FSM waits in WAIT before issuing at redirect_pc.
  - rvalid in the redirect cycle: data dropped, discard not set.
  - The next request after a redirect carries redirect_pc.
- Back-to-back redirects: the last one wins; discard stays set until the single outstanding response returns.
- rst low mid-operation: immediate return to reset values. Any outstanding memory response after reset is the memory's responsibility (memory is reset on the same rst).

Optional Feature:
- Macro: FETCH_ADDR_EXC_EN.
- Defined:
  - Extra output id_exc_adel (1 bit).
  - A PC with pc[1:0]!=0 issues no memory request. One queue entry is pushed with inst=0 and exc flag=1, then the FSM parks in IDLE until a redirect.
  - id_exc_adel follows the head entry.
- Undefined:
  - No port.
  - imem_addr = {pc[ADDR_W-1:2],2'b00}; the low PC bits are ignored.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum (IDLE, REQ, WAIT)
  - RESET_PC_DEFAULT, INST_NOP (32'h0)
  - fetch_entry_t struct {pc, inst, exc}
- Sub-module fetch_queue:
  - Synchronous FIFO of fetch_entry_t, Q_DEPTH deep.
  - Ports: push, pop, clear, count, head.
  - clear has priority over push/pop.

Test Plan:
- Reset release, memory gnt same cycle, rvalid 1 cycle later, id_ready=1 -> requests at BFC00000, BFC00004, ...; id_pc increments by 4; id_inst matches memory in order.
- id_ready=0 -> exactly 2 requests granted, then imem_req=0; id_ready=1 for one cycle -> one new request issued; no entry lost or duplicated.
- Redirect to 0x80001000 while in WAIT -> the pending rvalid data is never presented; next imem_addr=80001000; first id_pc=80001000.
- Redirect while imem_req=1 and gnt=0 -> imem_req=0 next cycle, then req at the target; no spurious rvalid expected.
- Push and pop in the same cycle with the queue full, across 100 random gnt/rvalid/ready delays -> id_pc stream strictly sequential; scoreboard matches.
- FETCH_ADDR_EXC_EN defined, redirect to 0x80001002 -> no imem_req; id_valid=1, id_exc_adel=1, id_pc=80001002, id_inst=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
// Provides the FSM state enum, the reset PC default, the NOP word and the
// queue entry struct {pc, inst, exc}.
package fetch_pkg;
   localparam int FETCH_ADDR_W = 32;
   localparam int FETCH_DATA_W = 32;
   localparam logic [FETCH_ADDR_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
   localparam logic [FETCH_DATA_W-1:0] INST_NOP = 32'h0;
   typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;
   typedef struct packed {
      logic [FETCH_ADDR_W-1:0] pc;
      logic [FETCH_DATA_W-1:0] inst;
      logic                    exc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/response bus plus decode handoff.
// imem_*: req/addr/gnt request handshake, rvalid/rdata in-order response.
// id_*: valid/ready handoff of {pc, inst} to decode.
// With FETCH_ADDR_EXC_EN defined, id_exc_adel flags a misaligned-PC entry.
interface fetch_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [DATA_W-1:0] imem_rdata;
   logic              id_valid;
   logic              id_ready;
   logic [ADDR_W-1:0] id_pc;
   logic [DATA_W-1:0] id_inst;
`ifdef FETCH_ADDR_EXC_EN
   logic              id_exc_adel;
`endif
   modport master (
`ifdef FETCH_ADDR_EXC_EN
      output id_exc_adel,
`endif
      output imem_req, imem_addr, id_valid, id_pc, id_inst,
      input  imem_gnt, imem_rvalid, imem_rdata, id_ready
   );
   modport slave (
`ifdef FETCH_ADDR_EXC_EN
      input  id_exc_adel,
`endif
      input  imem_req, imem_addr, id_valid, id_pc, id_inst,
      output imem_gnt, imem_rvalid, imem_rdata, id_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: registered FIFO of fetch entries, DEPTH deep (power of 2).
// Ports: clk, rst (sync, active-low), push/entry write, pop, clear (wins over
// push/pop), count occupancy, head = oldest entry (not bypassed from entry).
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CW = $clog2(DEPTH) + 1,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          clear,
   input  fetch_entry_t  entry,
   output logic [CW-1:0] count,
   output fetch_entry_t  head
);
   fetch_entry_t mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic do_pop;
   assign do_pop = pop && count != '0;
   assign head = mem[rd_ptr];
   // A push at full is only legal alongside a pop: the slot written is the
   // head being retired this same edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= entry;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage; owns the PC, issues one outstanding
// word request at a time and queues responses for decode.
// Ports: clk, rst (sync, active-low), redirect_valid/redirect_pc (flush and
// load PC), bus (fetch_if.master: imem request/response, id handoff).
// Optional FETCH_ADDR_EXC_EN: a misaligned PC pushes an exception entry
// (inst=0, id_exc_adel=1) instead of fetching, then parks until redirect.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W = FETCH_ADDR_W,
   parameter int DATA_W = FETCH_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int Q_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   fetch_if.master           bus
);
   localparam int CW = $clog2(Q_DEPTH) + 1;
   fetch_state_t state, state_d;
   logic [ADDR_W-1:0] pc, pc_d, req_pc, req_pc_d;
   logic discard, discard_d;
   logic push, pop, space;
   logic [CW-1:0] q_count, fill;
   fetch_entry_t push_entry, head;
   assign bus.imem_req  = state == REQ;
   assign bus.imem_addr = {pc[ADDR_W-1:2], 2'b00};
   assign bus.id_valid  = q_count != '0;
   assign bus.id_pc     = head.pc;
   assign bus.id_inst   = head.inst;
   assign pop   = bus.id_valid && bus.id_ready;
   // IDLE never has a request outstanding, so free space is just q_count.
   assign space = q_count < CW'(Q_DEPTH);
   // Occupancy after the response in WAIT lands (discarded data takes no slot).
   assign fill  = q_count + CW'(!discard) - CW'(pop);
`ifdef FETCH_ADDR_EXC_EN
   logic parked, parked_d, misaligned;
   assign misaligned      = pc[1:0] != 2'b00;
   assign bus.id_exc_adel = head.exc;
`else
   logic unused_exc;
   assign unused_exc = head.exc;
`endif
   always_comb begin
      state_d    = state;
      pc_d       = pc;
      req_pc_d   = req_pc;
      discard_d  = discard;
      push       = 1'b0;
      push_entry = '{pc: req_pc, inst: bus.imem_rdata, exc: 1'b0};
`ifdef FETCH_ADDR_EXC_EN
      parked_d   = parked;
`endif
      case (state)
         IDLE: begin
`ifdef FETCH_ADDR_EXC_EN
            if (misaligned) begin
               push       = !parked && space;
               push_entry = '{pc: pc, inst: INST_NOP, exc: 1'b1};
               parked_d   = parked || space;
            end else
`endif
            if (space) state_d = REQ;
         end
         REQ: if (bus.imem_gnt) begin
            pc_d     = pc + ADDR_W'(4);
            req_pc_d = bus.imem_addr;
            state_d  = WAIT;
         end
         WAIT: if (bus.imem_rvalid) begin
            push      = !discard;
            discard_d = 1'b0;
            state_d   = fill < CW'(Q_DEPTH) ? REQ : IDLE;
`ifdef FETCH_ADDR_EXC_EN
            if (misaligned) state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
      // Redirect overrides everything; a response still owed by memory must
      // be waited out and dropped before fetching from the new PC.
      if (redirect_valid) begin
         pc_d      = redirect_pc;
         push      = 1'b0;
         discard_d = (state == REQ && bus.imem_gnt) || (state == WAIT && !bus.imem_rvalid);
         state_d   = discard_d ? WAIT : IDLE;
`ifdef FETCH_ADDR_EXC_EN
         parked_d  = 1'b0;
`endif
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         req_pc  <= '0;
         discard <= 1'b0;
`ifdef FETCH_ADDR_EXC_EN
         parked  <= 1'b0;
`endif
      end else begin
         state   <= state_d;
         pc      <= pc_d;
         req_pc  <= req_pc_d;
         discard <= discard_d;
`ifdef FETCH_ADDR_EXC_EN
         parked  <= parked_d;
`endif
      end
   end
   fetch_queue #(.DEPTH(Q_DEPTH)) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .clear (redirect_valid),
      .entry (push_entry),
      .count (q_count),
      .head  (head)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit with a memory model and
// a scoreboard of expected {pc, inst} pairs pushed on each memory response.
module tb_fetch_unit;
   import fetch_pkg::*;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   fetch_if bus ();
   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .bus            (bus)
   );
   always #5 clk = ~clk;
   int checks = 0;
   int errors = 0;
   exp_t sb [$];
   bit busy = 0, stale = 0, do_redirect = 0, want_pc = 0, want_gnt = 0;
   int lat = 0, grants = 0, pops = 0;
   int gnt_pct = 100, rdy_pct = 100, redir_pct = 0, lat_max = 1;
   logic [31:0] busy_addr = '0, exp_req = 32'hBFC0_0000, redir_target = '0;
   logic [31:0] first_pc = '0, first_gnt = '0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ~a ^ 32'h5A5A_0000;
   endfunction
   // Drive one cycle of inputs at the negedge, account for the handshakes
   // that complete at the coming posedge, then wait for the next negedge.
   task automatic step();
      exp_t e;
      if (!do_redirect && $urandom_range(99) < redir_pct) begin
         do_redirect  = 1;
         redir_target = 32'h8000_0000 + ($urandom_range(255) << 2);
      end
      redirect_valid  = do_redirect;
      redirect_pc     = redir_target;
      do_redirect     = 0;
      bus.imem_rvalid = busy && lat == 0;
      bus.imem_rdata  = bus.imem_rvalid ? mem_word(busy_addr) : 32'h0;
      bus.imem_gnt    = !busy && $urandom_range(99) < gnt_pct;
      bus.id_ready    = $urandom_range(99) < rdy_pct;
      if (!redirect_valid && bus.id_valid && bus.id_ready) begin
         check("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("id_pc", bus.id_pc, e.pc);
            check("id_inst", bus.id_inst, e.inst);
         end
         if (want_pc) first_pc = bus.id_pc;
         want_pc = 0;
         pops++;
      end
      if (bus.imem_rvalid) begin
         busy = 0;
         if (!stale && !redirect_valid) sb.push_back('{busy_addr, mem_word(busy_addr)});
      end else if (busy) lat--;
      if (bus.imem_req && bus.imem_gnt) begin
         check("imem_addr", bus.imem_addr, exp_req);
         if (want_gnt) first_gnt = bus.imem_addr;
         want_gnt  = 0;
         grants++;
         busy      = 1;
         busy_addr = bus.imem_addr;
         lat       = $urandom_range(lat_max - 1, 0);
         stale     = redirect_valid;
         exp_req   = exp_req + 4;
      end
      if (redirect_valid) begin
         sb.delete();
         if (busy) stale = 1;
         exp_req  = redirect_pc;
         want_pc  = 1;
         want_gnt = 1;
      end
      @(negedge clk);
   endtask
   task automatic redirect_to(input logic [31:0] target);
      do_redirect  = 1;
      redir_target = target;
      step();
   endtask
   initial begin
      int g0, p0;
      bus.imem_gnt = 0;
      bus.imem_rvalid = 0;
      bus.imem_rdata = '0;
      bus.id_ready = 0;
      @(negedge clk);
      repeat (3) step();
      check("rst_req", bus.imem_req, 0);
      check("rst_valid", bus.id_valid, 0);
      check("rst_pc", bus.id_pc, 0);
      check("rst_inst", bus.id_inst, 0);
      rst = 1;
      step();
      check("first_req", bus.imem_req, 1);
      check("first_addr", bus.imem_addr, 32'hBFC0_0000);
      p0 = pops;
      repeat (40) step();
      check("stream_pops", (pops - p0) >= 15, 1);
      // Backpressure: with decode stalled only Q_DEPTH fetches may complete.
      rdy_pct = 0;
      redirect_to(32'h8000_0000);
      g0 = grants;
      repeat (20) step();
      check("stall_grants", grants - g0, 2);
      check("stall_req", bus.imem_req, 0);
      check("stall_valid", bus.id_valid, 1);
      g0 = grants;
      rdy_pct = 100;
      step();
      rdy_pct = 0;
      repeat (10) step();
      check("one_pop_one_grant", grants - g0, 1);
      check("stall_first_pc", first_pc, 32'h8000_0000);
      rdy_pct = 100;
      repeat (10) step();
      // Redirect while a response is outstanding.
      lat_max = 4;
      for (int i = 0; i < 50 && !(busy && lat > 0); i++) step();
      check("wait_reached", busy && lat > 0, 1);
      redirect_to(32'h8000_1000);
      lat_max = 1;
      repeat (30) step();
      check("wait_redir_gnt", first_gnt, 32'h8000_1000);
      check("wait_redir_pc", first_pc, 32'h8000_1000);
      // Redirect while a request is waiting for its grant.
      gnt_pct = 0;
      for (int i = 0; i < 50 && !bus.imem_req; i++) step();
      check("req_reached", bus.imem_req, 1);
      redirect_to(32'h8000_2000);
      check("abandon_req", bus.imem_req, 0);
      gnt_pct = 100;
      step();
      check("abandon_next_req", bus.imem_req, 1);
      check("abandon_next_addr", bus.imem_addr, 32'h8000_2000);
      repeat (10) step();
      // Random delays, full-queue push/pop overlap, occasional redirects.
      gnt_pct = 60;
      rdy_pct = 50;
      lat_max = 3;
      p0 = pops;
      repeat (300) step();
      redir_pct = 2;
      repeat (300) step();
      redir_pct = 0;
      check("random_pops", (pops - p0) >= 50, 1);
`ifdef FETCH_ADDR_EXC_EN
      rdy_pct = 0;
      gnt_pct = 100;
      redirect_to(32'h8000_1002);
      g0 = grants;
      repeat (10) step();
      check("exc_no_grant", grants - g0, 0);
      check("exc_req", bus.imem_req, 0);
      check("exc_valid", bus.id_valid, 1);
      check("exc_flag", bus.id_exc_adel, 1);
      check("exc_pc", bus.id_pc, 32'h8000_1002);
      check("exc_inst", bus.id_inst, 0);
      redirect_to(32'h8000_3000);
      rdy_pct = 100;
      repeat (20) step();
      check("exc_resume_gnt", first_gnt, 32'h8000_3000);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
